pcs_tx_encoder: RTL and testbench

- Transmit 64b/66b encoder and scrambler: the PCS stage directly downstream of `tx_mac`.
- Consumes 32-bit XGMII words plus 4 control bits, pairs them into 8-lane blocks and encodes each block.
- Emits 66-bit blocks as a 2-bit sync header plus 64-bit scrambled payload to the gearbox.
- Relays gearbox back-pressure to the MAC as `i_xgmii_pause`.

---
 rtl/pcs_pkg.sv | 36 +++
 rtl/pcs_scrambler.sv | 25 ++
 rtl/pcs_tx_encoder.sv | 103 ++++++++++
 tb/tb_pcs_tx_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// pcs_pkg: XGMII characters, 64b/66b block types and the reference scrambler.
package pcs_pkg;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_S4   = 8'h33;
    // Terminate block types, byte k holds the type for T in lane k
    localparam logic [63:0] BT_TERM = 64'hFFE1D2CC_B4AA9987;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam logic [63:0] ERR_PAYLOAD = {{8{7'h1E}}, BT_IDLE};

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } pcs_block_t;

    // Returns {next_state, scrambled}; bit 0 is scrambled first
    function automatic logic [121:0] scramble(input logic [57:0] state, input logic [63:0] din);
        logic [57:0] s;
        logic [63:0] dout;
        s = state;
        dout = '0;
        for (int i = 0; i < 64; i++) begin
            dout[i] = din[i] ^ s[38] ^ s[57];
            s = {s[56:0], dout[i]};
        end
        return {s, dout};
    endfunction
endpackage

// File: rtl/pcs_scrambler.sv
// pcs_scrambler: x^58+x^39+1 self-synchronous scrambler over a 64-bit payload.
module pcs_scrambler
    import pcs_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_advance,
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);
    logic [57:0]  state_q, state_d;
    logic [121:0] res;

    always_comb begin
        res = scramble(state_q, i_data);
        state_d = i_advance ? res[121:64] : state_q;
        o_data = i_en ? res[63:0] : i_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= '1;
        else state_q <= state_d;
    end
endmodule

// File: rtl/pcs_tx_encoder.sv
// pcs_tx_encoder: pairs XGMII words into 8-lane blocks, 64b/66b encodes and scrambles them.
module pcs_tx_encoder
    import pcs_pkg::*;
#(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_CTRL_WIDTH = 4,
    parameter int SCRAMBLE_EN      = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_txd,
    input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
    input  logic                        i_xgmii_valid,
    output logic                        o_xgmii_pause,
    output logic [63:0]                 o_tx_data,
    output logic [1:0]                  o_tx_hdr,
    output logic                        o_tx_valid,
    input  logic                        i_tx_pause
);
    logic                        phase_q, phase_d;
    logic [XGMII_DATA_WIDTH-1:0] lo_txd_q, lo_txd_d;
    logic [XGMII_CTRL_WIDTH-1:0] lo_ctrl_q, lo_ctrl_d;
    logic [63:0]                 tx_data_q, tx_data_d;
    logic [1:0]                  tx_hdr_q, tx_hdr_d;
    logic                        tx_valid_q, tx_valid_d;
    logic                        pause_q, pause_d;
    logic                        go;
    logic [63:0]                 d, scr_data;
    logic [7:0]                  c, idle, lo_m, hi_m;
    pcs_block_t                  blk;

    always_comb begin
        go = i_xgmii_valid && phase_q;
        phase_d = i_xgmii_valid ? !phase_q : phase_q;
        lo_txd_d = (i_xgmii_valid && !phase_q) ? i_xgmii_txd : lo_txd_q;
        lo_ctrl_d = (i_xgmii_valid && !phase_q) ? i_xgmii_ctrl : lo_ctrl_q;
        d = {i_xgmii_txd, lo_txd_q};
        c = {i_xgmii_ctrl, lo_ctrl_q};
        for (int i = 0; i < 8; i++) idle[i] = c[i] && d[8*i +: 8] == XGMII_IDLE;
        lo_m = '0;
        hi_m = '0;
        blk.hdr = HDR_CTRL;
        blk.data = ERR_PAYLOAD;
        if (c == 8'h00) begin
            blk.hdr = HDR_DATA;
            blk.data = d;
        end else if (idle == 8'hFF) begin
            blk.data = {56'h0, BT_IDLE};
        end else if (c == 8'h01 && d[7:0] == XGMII_START) begin
            blk.data = {d[63:8], BT_S0};
        end else if (idle[3:0] == 4'hF && c[7:4] == 4'h1 && d[39:32] == XGMII_START) begin
            blk.data = {d[63:40], 32'h0, BT_S4};
        end else begin
            // At most one lane can satisfy the terminate pattern
            for (int k = 0; k < 8; k++) begin
                lo_m = 8'((1 << k) - 1);
                hi_m = ~8'((2 << k) - 1);
                if (c[k] && d[8*k +: 8] == XGMII_TERM && (c & lo_m) == 8'h00 && (idle & hi_m) == hi_m) begin
                    blk.data[7:0] = BT_TERM[8*k +: 8];
                    for (int j = 1; j < 8; j++) blk.data[8*j +: 8] = (j <= k) ? d[8*(j-1) +: 8] : 8'h00;
                end
            end
        end
        tx_valid_d = go;
        tx_data_d = go ? scr_data : tx_data_q;
        tx_hdr_d = go ? blk.hdr : tx_hdr_q;
        pause_d = i_tx_pause;
    end

    pcs_scrambler u_scr (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_en     (SCRAMBLE_EN != 0),
        .i_advance(go),
        .i_data   (blk.data),
        .o_data   (scr_data)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase_q    <= 1'b0;
            lo_txd_q   <= '0;
            lo_ctrl_q  <= '0;
            tx_data_q  <= '0;
            tx_hdr_q   <= 2'b00;
            tx_valid_q <= 1'b0;
            pause_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            lo_txd_q   <= lo_txd_d;
            lo_ctrl_q  <= lo_ctrl_d;
            tx_data_q  <= tx_data_d;
            tx_hdr_q   <= tx_hdr_d;
            tx_valid_q <= tx_valid_d;
            pause_q    <= pause_d;
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_hdr      = tx_hdr_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_xgmii_pause = pause_q;
endmodule

// File: tb/tb_pcs_tx_encoder.sv
// tb_pcs_tx_encoder: directed and random checks of the encoder, unscrambled and scrambled instances.
module tb_pcs_tx_encoder;
    import pcs_pkg::*;

    localparam int K_D = 0, K_I = 1, K_S = 2, K_T = 3, K_O = 4;
    localparam logic [63:0] ERR = {{8{7'h1E}}, 8'h1E};

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, tx_pause = 1'b0;
    logic [31:0] txd = '0;
    logic [3:0]  ctrl = '0;
    logic        p0, p1, v0, v1;
    logic [63:0] d0, d1;
    logic [1:0]  h0, h1;
    int          tests = 0, fails = 0;
    bit          sq[$], dq[$];
    logic [57:0] ps;

    always #5 clk = ~clk;

    pcs_tx_encoder #(.SCRAMBLE_EN(0)) u0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_xgmii_txd(txd), .i_xgmii_ctrl(ctrl),
        .i_xgmii_valid(valid), .o_xgmii_pause(p0), .o_tx_data(d0), .o_tx_hdr(h0),
        .o_tx_valid(v0), .i_tx_pause(tx_pause)
    );

    pcs_tx_encoder #(.SCRAMBLE_EN(1)) u1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_xgmii_txd(txd), .i_xgmii_ctrl(ctrl),
        .i_xgmii_valid(valid), .o_xgmii_pause(p1), .o_tx_data(d1), .o_tx_hdr(h1),
        .o_tx_valid(v1), .i_tx_pause(tx_pause)
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scrambler history: the last 58 line bits, all ones after reset
    task automatic model_reset();
        sq = {};
        dq = {};
        for (int i = 0; i < 58; i++) begin
            sq.push_back(1'b1);
            dq.push_back(1'b1);
        end
        ps = '1;
    endtask

    task automatic scr_model(input logic [63:0] p, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = p[i] ^ sq[sq.size()-39] ^ sq[sq.size()-58];
            sq.push_back(o[i]);
            void'(sq.pop_front());
        end
    endtask

    task automatic descr_model(input logic [63:0] r, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = r[i] ^ dq[dq.size()-39] ^ dq[dq.size()-58];
            dq.push_back(r[i]);
            void'(dq.pop_front());
        end
    endtask

    function automatic logic [65:0] model_enc(input logic [63:0] d, input logic [7:0] c);
        int kind [8];
        int tpos;
        bit ok;
        logic [127:0] w;
        logic [7:0] tt [8];
        tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        for (int i = 0; i < 8; i++)
            kind[i] = !c[i] ? K_D : d[8*i +: 8] == 8'h07 ? K_I : d[8*i +: 8] == 8'hFB ? K_S :
                      d[8*i +: 8] == 8'hFD ? K_T : K_O;
        if (c == 8'h00) return {2'b01, d};
        ok = 1;
        for (int i = 0; i < 8; i++) ok = ok && kind[i] == K_I;
        if (ok) return {2'b10, 64'h1E};
        ok = kind[0] == K_S;
        for (int i = 1; i < 8; i++) ok = ok && kind[i] == K_D;
        if (ok) return {2'b10, d[63:8], 8'h78};
        ok = kind[4] == K_S;
        for (int i = 0; i < 8; i++) if (i != 4) ok = ok && kind[i] == (i < 4 ? K_I : K_D);
        if (ok) return {2'b10, d[63:40], 32'h0, 8'h33};
        tpos = -1;
        for (int i = 7; i >= 0; i--) if (kind[i] == K_T) tpos = i;
        if (tpos >= 0) begin
            ok = 1;
            for (int i = 0; i < 8; i++) begin
                if (i < tpos) ok = ok && kind[i] == K_D;
                if (i > tpos) ok = ok && kind[i] == K_I;
            end
            if (ok) begin
                w = ({64'h0, d} << 8) & ((128'h1 << (8*tpos + 8)) - 128'h1);
                w[7:0] = tt[tpos];
                return {2'b10, w[63:0]};
            end
        end
        return {2'b10, ERR};
    endfunction

    task automatic drive(input logic [31:0] w, input logic [3:0] c, input logic v);
        @(negedge clk);
        txd = w;
        ctrl = c;
        valid = v;
    endtask

    task automatic check_block(input string tag, input logic [1:0] eh, input logic [63:0] ep);
        logic [63:0]  so, rec;
        logic [121:0] r;
        chk({tag, " valid"}, {v1, v0}, 2'b11);
        chk({tag, " hdr"}, h0, eh);
        chk({tag, " data"}, d0, ep);
        chk({tag, " scr hdr"}, h1, eh);
        scr_model(ep, so);
        chk({tag, " scr data"}, d1, so);
        r = scramble(ps, ep);
        ps = r[121:64];
        chk({tag, " pkg scr"}, d1, r[63:0]);
        descr_model(d1, rec);
        chk({tag, " loopback"}, rec, ep);
    endtask

    task automatic blk(input string tag, input logic [63:0] d, input logic [7:0] c, input int gap,
                       input logic [1:0] eh, input logic [63:0] ep);
        drive(d[31:0], c[3:0], 1'b1);
        chk({tag, " idle0"}, {v1, v0}, 2'b00);
        for (int g = 0; g < gap; g++) begin
            drive($urandom, 4'($urandom), 1'b0);
            chk({tag, " gap"}, {v1, v0}, 2'b00);
        end
        drive(d[63:32], c[7:4], 1'b1);
        chk({tag, " idle1"}, {v1, v0}, 2'b00);
        drive($urandom, 4'h0, 1'b0);
        check_block(tag, eh, ep);
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        logic [65:0] e;
        int          kind, k;

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst data", {d1, d0}, 128'h0);
        chk("rst hdr", {h1, h0}, 4'h0);
        chk("rst valid", {v1, v0}, 2'b00);
        chk("rst pause", {p1, p0}, 2'b00);
        rst_n = 1'b1;

        blk("idle", {2{32'h07070707}}, 8'hFF, 0, 2'b10, 64'h000000000000001E);
        blk("start0", {32'hD5555555, 32'h555555FB}, 8'h01, 0, 2'b10, 64'hD555555555555578);
        blk("data", 64'h1122334455667788, 8'h00, 0, 2'b01, 64'h1122334455667788);
        blk("term3", {32'h07070707, 32'hFD332211}, 8'hF8, 0, 2'b10, 64'h00000000332211B4);
        blk("error", {32'h44444444, 32'h33FE1111}, 8'h04, 0, 2'b10, ERR);
        blk("start4", {32'hAABBCCFB, 32'h07070707}, 8'h1F, 1, 2'b10, 64'hAABBCC0000000033);
        blk("term0", {32'h07070707, 32'h070707FD}, 8'hFF, 2, 2'b10, 64'h0000000000000087);
        blk("term7", 64'hFD66554433221100, 8'h80, 0, 2'b10, 64'h66554433221100FF);
        blk("badstart", {32'h44444444, 32'h33FB1111}, 8'h04, 0, 2'b10, ERR);

        drive(32'h55667788, 4'h0, 1'b1);
        drive(32'h11223344, 4'h0, 1'b1);
        drive(32'h07070707, 4'hF, 1'b1);
        check_block("b2b a", 2'b01, 64'h1122334455667788);
        drive(32'h07070707, 4'hF, 1'b1);
        chk("b2b gap", {v1, v0}, 2'b00);
        drive(32'h0, 4'h0, 1'b0);
        check_block("b2b b", 2'b10, 64'h1E);

        drive(32'h555555FB, 4'h1, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst data", {d1, d0}, 128'h0);
        chk("midrst hdr", {h1, h0}, 4'h0);
        chk("midrst valid", {v1, v0}, 2'b00);
        rst_n = 1'b1;
        blk("post rst", {32'h07070707, 32'hFD332211}, 8'hF8, 0, 2'b10, 64'h00000000332211B4);

        @(negedge clk);
        tx_pause = 1'b1;
        chk("pause pre", {p1, p0}, 2'b00);
        @(negedge clk);
        chk("pause rise", {p1, p0}, 2'b11);
        blk("paused blk", 64'h0123456789ABCDEF, 8'h00, 0, 2'b01, 64'h0123456789ABCDEF);
        tx_pause = 1'b0;
        chk("pause hold", {p1, p0}, 2'b11);
        @(negedge clk);
        chk("pause fall", {p1, p0}, 2'b00);

        for (int n = 0; n < 1000; n++) begin
            kind = $urandom_range(0, 5);
            d = {$urandom, $urandom};
            c = 8'h00;
            k = $urandom_range(0, 7);
            case (kind)
                1: begin d = {8{XGMII_IDLE}}; c = 8'hFF; end
                2: begin d[7:0] = XGMII_START; c = 8'h01; end
                3: begin d[39:0] = {XGMII_START, {4{XGMII_IDLE}}}; c = 8'h1F; end
                4: for (int i = k; i < 8; i++) begin
                    d[8*i +: 8] = (i == k) ? XGMII_TERM : XGMII_IDLE;
                    c[i] = 1'b1;
                end
                5: begin
                    c = 8'($urandom);
                    for (int i = 0; i < 8; i++) if (c[i]) begin
                        case ($urandom_range(0, 4))
                            0: d[8*i +: 8] = XGMII_IDLE;
                            1: d[8*i +: 8] = XGMII_START;
                            2: d[8*i +: 8] = XGMII_TERM;
                            3: d[8*i +: 8] = XGMII_ERROR;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
            e = model_enc(d, c);
            blk("rnd", d, c, $urandom_range(0, 2), e[65:64], e[63:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
